// File: rtl/fpu_cmp_minmax.sv
// Two-stage pipelined binary32 compare / min-max / classify unit with valid-ready on both sides.
// Optional sticky NV accumulator (flags_clr / flags_nv) is built when FPU_CMP_FFLAGS_EN is defined.
module fpu_cmp_minmax #(
    parameter int          TAG_W     = 5,
    parameter logic [31:0] NAN_CANON = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_nv,
    output logic [TAG_W-1:0] out_tag
`ifdef FPU_CMP_FFLAGS_EN
    ,
    input  logic             flags_clr,
    output logic             flags_nv
`endif
);

    typedef enum logic [2:0] {
        OP_FMIN   = 3'b000,
        OP_FMAX   = 3'b001,
        OP_FLE    = 3'b010,
        OP_FLT    = 3'b011,
        OP_FEQ    = 3'b100,
        OP_FCLASS = 3'b101,
        OP_RSVD6  = 3'b110,
        OP_RSVD7  = 3'b111
    } op_e;

    // One-hot class: 0 -inf, 1 -norm, 2 -sub, 3 -0, 4 +0, 5 +sub, 6 +norm, 7 +inf, 8 sNaN, 9 qNaN.
    function automatic logic [9:0] classify(input logic [31:0] x);
        logic [9:0] c;
        c = '0;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == '0) begin
                if (x[31]) c[0] = 1'b1;
                else       c[7] = 1'b1;
            end else if (x[22]) begin
                c[9] = 1'b1;
            end else begin
                c[8] = 1'b1;
            end
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == '0) begin
                if (x[31]) c[3] = 1'b1;
                else       c[4] = 1'b1;
            end else begin
                if (x[31]) c[2] = 1'b1;
                else       c[5] = 1'b1;
            end
        end else begin
            if (x[31]) c[1] = 1'b1;
            else       c[6] = 1'b1;
        end
        return c;
    endfunction

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_a_q, s1_a_d;
    logic [31:0]      s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [9:0]       s1_cls_a_q, s1_cls_a_d;
    logic [9:0]       s1_cls_b_q, s1_cls_b_d;

    // Stage 2 (output) registers
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic             out_nv_q, out_nv_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic s2_free;
    logic s1_advance;
    logic in_fire;

    // S2 can take new data when empty or when its current result leaves this cycle.
    assign s2_free    = !out_valid_q || out_ready;
    assign s1_advance = s1_valid_q && s2_free;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign in_fire    = in_valid && in_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        s1_cls_a_d = s1_cls_a_q;
        s1_cls_b_d = s1_cls_b_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = op_e'(in_op);
            s1_tag_d   = in_tag;
            s1_cls_a_d = classify(in_a);
            s1_cls_b_d = classify(in_b);
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // Execute: derived from registered class vectors and raw operand bits.
    logic        a_nan, b_nan, any_snan, ordered, both_zero;
    logic        mag_lt, mag_gt, lt_tot, lt, eq;
    logic [31:0] min_v, max_v, res_c;
    logic        nv_c;

    always_comb begin
        a_nan     = s1_cls_a_q[8] | s1_cls_a_q[9];
        b_nan     = s1_cls_b_q[8] | s1_cls_b_q[9];
        any_snan  = s1_cls_a_q[8] | s1_cls_b_q[8];
        ordered   = (|s1_cls_a_q[7:0]) && (|s1_cls_b_q[7:0]);
        both_zero = (s1_cls_a_q[3] | s1_cls_a_q[4]) && (s1_cls_b_q[3] | s1_cls_b_q[4]);
        mag_lt    = s1_a_q[30:0] < s1_b_q[30:0];
        mag_gt    = s1_a_q[30:0] > s1_b_q[30:0];

        // Total order with -0 < +0; used directly by min/max.
        if (s1_a_q[31] != s1_b_q[31]) lt_tot = s1_a_q[31];
        else if (s1_a_q[31])          lt_tot = mag_gt;
        else                          lt_tot = mag_lt;

        // Comparisons treat any pair of zeros as equal.
        lt = lt_tot && !both_zero;
        eq = (s1_a_q == s1_b_q) || both_zero;

        if (a_nan && b_nan) begin
            min_v = NAN_CANON;
            max_v = NAN_CANON;
        end else if (a_nan) begin
            min_v = s1_b_q;
            max_v = s1_b_q;
        end else if (b_nan) begin
            min_v = s1_a_q;
            max_v = s1_a_q;
        end else begin
            min_v = lt_tot ? s1_a_q : s1_b_q;
            max_v = lt_tot ? s1_b_q : s1_a_q;
        end

        res_c = '0;
        nv_c  = 1'b0;
        case (s1_op_q)
            OP_FMIN: begin
                res_c = min_v;
                nv_c  = any_snan;
            end
            OP_FMAX: begin
                res_c = max_v;
                nv_c  = any_snan;
            end
            OP_FLE: begin
                res_c = {31'b0, ordered && (lt || eq)};
                nv_c  = !ordered;
            end
            OP_FLT: begin
                res_c = {31'b0, ordered && lt};
                nv_c  = !ordered;
            end
            OP_FEQ: begin
                res_c = {31'b0, ordered && eq};
                nv_c  = any_snan;
            end
            OP_FCLASS: begin
                res_c = {22'b0, s1_cls_a_q};
            end
            default: begin
                res_c = '0;
                nv_c  = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_nv_d     = out_nv_q;
        out_tag_d    = out_tag_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = res_c;
                out_nv_d     = nv_c;
                out_tag_d    = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= OP_FMIN;
            s1_tag_q     <= '0;
            s1_cls_a_q   <= '0;
            s1_cls_b_q   <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_nv_q     <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_tag_q     <= s1_tag_d;
            s1_cls_a_q   <= s1_cls_a_d;
            s1_cls_b_q   <= s1_cls_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_nv_q     <= out_nv_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_nv     = out_nv_q;
    assign out_tag    = out_tag_q;

`ifdef FPU_CMP_FFLAGS_EN
    logic flags_nv_q, flags_nv_d;

    // Clear wins over a same-cycle accrual.
    always_comb begin
        flags_nv_d = flags_nv_q;
        if (flags_clr)
            flags_nv_d = 1'b0;
        else if (out_valid_q && out_ready && out_nv_q)
            flags_nv_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) flags_nv_q <= 1'b0;
        else     flags_nv_q <= flags_nv_d;
    end

    assign flags_nv = flags_nv_q;
`else
    // No sticky NV state in this build; per-result out_nv is the only flag output.
`endif

endmodule

// File: doc/fpu_cmp_minmax.md
Name: fpu_cmp_minmax

Overview:
- Two-stage pipelined single-precision compare and min/max unit. It sits directly downstream of the FPU classifier.
- It classifies both operands into the codebase's 10-bit one-hot class vector, registers them, and executes FMIN, FMAX, FLE, FLT, FEQ and FCLASS.
- Handshake is valid/ready on both sides. Results and the invalid-operation (NV) flag go to the FP writeback arbiter.

Parameters:
TAG_W, 5, width of the opaque tag (destination register id) carried alongside each operation
NAN_CANON, 32'h7FC00000, value returned by FMIN/FMAX when both operands are NaN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation request valid
in_ready  out  1  unit can accept a request this cycle
in_op  in  3  000 FMIN, 001 FMAX, 010 FLE, 011 FLT, 100 FEQ, 101 FCLASS, 110/111 reserved
in_a  in  32  operand rs1 (IEEE-754 binary32)
in_b  in  32  operand rs2 (ignored for FCLASS)
in_tag  in  TAG_W  tag carried unchanged to the output
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_result  out  32  result word
out_nv  out  1  invalid-operation flag for this result
out_tag  out  TAG_W  tag of this result
flags_clr  in  1  clear sticky NV; present only with FPU_CMP_FFLAGS_EN
flags_nv  out  1  sticky accrued NV; present only with FPU_CMP_FFLAGS_EN

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: out_valid=0, out_result=0, out_nv=0, out_tag=0, both stage-valid bits 0, flags_nv=0. in_ready=1 in the cycle after reset deasserts.
- Stage 1 (S1) captures the operands on in_valid && in_ready. It registers a, b, op, tag and the 10-bit class vectors of a and b. Class bit order: 0 -inf, 1 -normal, 2 -subnormal, 3 -zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN. A NaN is sNaN when mantissa bit 22 is 0 and qNaN when it is 1.
- Stage 2 (S2) computes the result and NV from the S1 registers and registers them as the outputs.
- Latency: exactly 2 cycles from an accepted input to out_valid, with no stall. Throughput is 1 per cycle.
- Stall rules:
  - S2 holds while out_valid && !out_ready.
  - S1 advances when S2 is empty or S2 is draining this cycle.
  - in_ready = !s1_valid || s1_advance.
  - No combinational path from in_valid to out_valid.
  - A stalled out_result, out_nv and out_tag stay stable until the handshake completes.
- Comparison: signed-magnitude. Any mix of ±0 compares equal for FEQ, FLT and FLE.
- FEQ: result 1 if equal, else 0. Any NaN operand gives 0. NV=1 only if either operand is sNaN.
- FLT/FLE: any NaN operand gives result 0 and NV=1 (qNaN or sNaN).
- FMIN/FMAX:
  - -0 is treated as less than +0. FMIN(+0,-0) = 0x80000000; FMAX(+0,-0) = 0x00000000.
  - If exactly one operand is NaN, return the other operand.
  - If both are NaN, return NAN_CANON.
  - NV=1 if either operand is sNaN.
- FCLASS: result = {22'b0, class(a)}. NV=0.
- Reserved ops (110/111): result 0, NV=0. The operation still flows through the pipeline and produces a handshake.
- Operands are taken as raw bits; no denormal flushing.
- Reset mid-operation: all in-flight operations are discarded. Nothing is emitted after reset.
- Simultaneous S2 drain and S1 advance in the same cycle: both happen, with no bubble.

Optional Feature:
- Macro: FPU_CMP_FFLAGS_EN.
- Defined:
  - Ports flags_clr and flags_nv exist.
  - flags_nv sets to 1 on any output handshake (out_valid && out_ready) with out_nv=1. It stays set until flags_clr.
  - flags_clr has priority over a same-cycle set. It clears the flag, and the same-cycle NV is dropped.
  - Reset value 0.
- Undefined: neither port exists, and there is no sticky register. Per-result out_nv is unchanged.

Test Plan:
- FLT a=0x3F800000 (1.0), b=0x40000000 (2.0), tag=3, out_ready=1 -> two cycles later out_result=1, out_nv=0, out_tag=3.
- FEQ a=0x00000000, b=0x80000000 -> result 1, nv 0. FMIN on the same operands -> 0x80000000. FMAX on the same operands -> 0x00000000.
- FMIN a=0x7F800001 (sNaN), b=0x3F800000 -> result 0x3F800000, nv 1. FMAX a=b=0x7FC00001 -> 0x7FC00000, nv 0.
- FLE a=0x7FC00000 (qNaN), b=0 -> result 0, nv 1. FEQ on the same operands -> result 0, nv 0.
- FCLASS a=0x00000001 -> 0x00000020. FCLASS a=0xFF800000 -> 0x00000001. FCLASS a=0x7F800001 -> 0x00000100.
- Backpressure: issue 4 back-to-back ops with out_ready=0 for 3 cycles.
  - in_ready drops after 2 ops are accepted.
  - The outputs are held stable while stalled.
  - After release, all 4 results emerge in order with correct tags and no loss or duplication.
  - Assert rst mid-stream: out_valid=0 the next cycle.
  - With FPU_CMP_FFLAGS_EN, flags_nv=1 after the sNaN case and 0 after flags_clr.
